sp_exec_pipe: RTL and testbench

SP_EXEC_PIPE -- requirements
Module: sp_exec_pipe

---
 rtl/sp_exec_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_sp_exec_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sp_exec_pipe
//  Purpose  : Fixed-latency SIMD execute pipeline with two completion points.
//             Short-class ops (AH, SFH) retire on the wb port LAT_SHORT cycles
//             after issue. Long-class ops (MPY, MPYU, MPYH, MPYA) retire on the
//             int port LAT_LONG cycles after issue. The pipeline never stalls.
//             Results are computed in the issue cycle and then carried down
//             a shift register of stages.
//
//  Ports    : clk                 - sole clock, rising edge
//             reset               - synchronous, active low
//             flush               - kills in-flight and same-cycle issue
//             issue_valid, op     - instruction present / decoded opcode
//             rt_addr, reg_write  - destination register and write enable
//             ra, rb, rc          - LANES x 32-bit source operands
//             rt_wb/rt_addr_wb/reg_write_wb    - short-class writeback
//             rt_int/rt_addr_int/reg_write_int - long-class writeback
//             illegal_op          - one-cycle pulse after an unknown opcode
//             busy                - any stage holds a valid entry
//             fwd_tap             - per-stage {valid, rt_addr, class, result}
//                                   (present only with SP_EXEC_FWD_TAP_EN)
//
//  Config   : `define SP_EXEC_FWD_TAP_EN adds the fwd_tap output.
//
//  Bit order: vectors are [0:N]; bit 0 is the MSB. Lane i is [i*32 +: 32],
//             and inside a lane the high halfword comes first.
//
//  Revision : 1.0 - initial release
// ============================================================================
module sp_exec_pipe #(
    parameter int LANES     = 4,
    parameter int LAT_SHORT = 6,
    parameter int LAT_LONG  = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [0:10]            op,
    input  logic [0:6]             rt_addr,
    input  logic [0:LANES*32-1]    ra,
    input  logic [0:LANES*32-1]    rb,
    input  logic [0:LANES*32-1]    rc,
    input  logic                   reg_write,
    output logic [0:LANES*32-1]    rt_wb,
    output logic [0:6]             rt_addr_wb,
    output logic                   reg_write_wb,
    output logic [0:LANES*32-1]    rt_int,
    output logic [0:6]             rt_addr_int,
    output logic                   reg_write_int,
    output logic                   illegal_op,
    output logic                   busy
`ifdef SP_EXEC_FWD_TAP_EN
    ,
    output logic [0:LAT_LONG*(9+LANES*32)-1] fwd_tap
`endif
);

    localparam int c_DW    = LANES * 32;
    localparam int c_TAP_W = 9 + c_DW;

    // Opcodes
    localparam logic [0:10] c_OP_AH   = 11'b00011001000;
    localparam logic [0:10] c_OP_SFH  = 11'b00001001000;
    localparam logic [0:10] c_OP_MPY  = 11'b01111000100;
    localparam logic [0:10] c_OP_MPYU = 11'b01111001100;
    localparam logic [0:10] c_OP_MPYH = 11'b01111000101;

    // Internal function selector
    localparam logic [2:0] c_FN_AH   = 3'd0;
    localparam logic [2:0] c_FN_SFH  = 3'd1;
    localparam logic [2:0] c_FN_MPY  = 3'd2;
    localparam logic [2:0] c_FN_MPYU = 3'd3;
    localparam logic [2:0] c_FN_MPYH = 3'd4;
    localparam logic [2:0] c_FN_MPYA = 3'd5;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0] w_fn;
    logic       w_long;
    logic       w_legal;
    logic       w_illegal;

    always_comb begin
        w_fn      = c_FN_AH;
        w_long    = 1'b0;
        w_legal   = 1'b0;
        w_illegal = 1'b0;
        if (op == c_OP_AH) begin
            w_fn    = c_FN_AH;
            w_legal = 1'b1;
        end else if (op == c_OP_SFH) begin
            w_fn    = c_FN_SFH;
            w_legal = 1'b1;
        end else if (op == c_OP_MPY) begin
            w_fn    = c_FN_MPY;
            w_long  = 1'b1;
            w_legal = 1'b1;
        end else if (op == c_OP_MPYU) begin
            w_fn    = c_FN_MPYU;
            w_long  = 1'b1;
            w_legal = 1'b1;
        end else if (op == c_OP_MPYH) begin
            w_fn    = c_FN_MPYH;
            w_long  = 1'b1;
            w_legal = 1'b1;
        end else if (op[0:3] == 4'b1100) begin
            // MPYA is an RRR-form op, so only the top four bits select it.
            w_fn    = c_FN_MPYA;
            w_long  = 1'b1;
            w_legal = 1'b1;
        end else if (op[0:9] == 10'd0) begin
            // NOP: a bubble that is not flagged as illegal.
            w_legal = 1'b0;
        end else begin
            w_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane datapath (issue-cycle compute)
    // ------------------------------------------------------------------
    wire [0:c_DW-1] w_issue_res;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [15:0] w_a_hi;
        logic [15:0] w_a_lo;
        logic [15:0] w_b_hi;
        logic [15:0] w_b_lo;
        logic [31:0] w_c;
        logic [31:0] w_prod_s;
        logic [31:0] w_prod_u;
        logic [15:0] w_prod_h;
        logic [31:0] w_res;

        assign w_a_hi = ra[i*32 +: 16];
        assign w_a_lo = ra[i*32+16 +: 16];
        assign w_b_hi = rb[i*32 +: 16];
        assign w_b_lo = rb[i*32+16 +: 16];
        assign w_c    = rc[i*32 +: 32];

        assign w_prod_s = $signed({{16{w_a_lo[15]}}, w_a_lo})
                        * $signed({{16{w_b_lo[15]}}, w_b_lo});
        assign w_prod_u = {16'd0, w_a_lo} * {16'd0, w_b_lo};
        // Only the low 16 bits of hi*lo survive the left shift by 16.
        assign w_prod_h = w_a_hi * w_b_lo;

        always_comb begin
            w_res = '0;
            case (w_fn)
                c_FN_AH:   w_res = {w_a_hi + w_b_hi, w_a_lo + w_b_lo};
                c_FN_SFH:  w_res = {w_b_hi - w_a_hi, w_b_lo - w_a_lo};
                c_FN_MPY:  w_res = w_prod_s;
                c_FN_MPYU: w_res = w_prod_u;
                c_FN_MPYH: w_res = {w_prod_h, 16'd0};
                c_FN_MPYA: w_res = w_prod_s + w_c;
                default:   w_res = '0;
            endcase
        end

        assign w_issue_res[i*32 +: 32] = w_res;
    end

    // ------------------------------------------------------------------
    // Pipeline stages 1..LAT_LONG. An entry issued in cycle t sits in
    // stage k during cycle t+k. Short entries leave after LAT_SHORT so they
    // do not keep busy asserted past their own writeback.
    // ------------------------------------------------------------------
    logic             r_valid [1:LAT_LONG];
    logic             r_long  [1:LAT_LONG];
    logic [0:6]       r_addr  [1:LAT_LONG];
    logic             r_regw  [1:LAT_LONG];
    logic [0:c_DW-1]  r_res   [1:LAT_LONG];
    logic             r_illegal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= LAT_LONG; k++) begin
                r_valid[k] <= 1'b0;
                r_long[k]  <= 1'b0;
                r_addr[k]  <= '0;
                r_regw[k]  <= 1'b0;
                r_res[k]   <= '0;
            end
            r_illegal <= 1'b0;
        end else begin
            r_valid[1] <= issue_valid && w_legal && !flush;
            r_long[1]  <= w_long;
            r_addr[1]  <= rt_addr;
            r_regw[1]  <= reg_write;
            r_res[1]   <= w_issue_res;
            for (int k = 2; k <= LAT_LONG; k++) begin
                r_valid[k] <= !flush && r_valid[k-1]
                              && (r_long[k-1] || ((k - 1) < LAT_SHORT));
                r_long[k]  <= r_long[k-1];
                r_addr[k]  <= r_addr[k-1];
                r_regw[k]  <= r_regw[k-1];
                r_res[k]   <= r_res[k-1];
            end
            r_illegal <= issue_valid && w_illegal && !flush;
        end
    end

    // ------------------------------------------------------------------
    // Writeback ports: zero unless an entry of the port's class completes.
    // ------------------------------------------------------------------
    logic w_s_done;
    logic w_l_done;

    assign w_s_done = r_valid[LAT_SHORT] && !r_long[LAT_SHORT];
    assign w_l_done = r_valid[LAT_LONG]  &&  r_long[LAT_LONG];

    assign rt_wb         = w_s_done ? r_res[LAT_SHORT]  : '0;
    assign rt_addr_wb    = w_s_done ? r_addr[LAT_SHORT] : '0;
    assign reg_write_wb  = w_s_done && r_regw[LAT_SHORT];

    assign rt_int        = w_l_done ? r_res[LAT_LONG]  : '0;
    assign rt_addr_int   = w_l_done ? r_addr[LAT_LONG] : '0;
    assign reg_write_int = w_l_done && r_regw[LAT_LONG];

    assign illegal_op    = r_illegal;

    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= LAT_LONG; k++) begin
            busy = busy | r_valid[k];
        end
    end

`ifdef SP_EXEC_FWD_TAP_EN
    // Entry k of the tap describes stage k+1; class bit is 1 for long ops.
    always_comb begin
        fwd_tap = '0;
        for (int k = 0; k < LAT_LONG; k++) begin
            fwd_tap[k*c_TAP_W +: c_TAP_W] =
                {r_valid[k+1], r_addr[k+1], r_long[k+1], r_res[k+1]};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp_exec_pipe
//  Purpose  : Self-checking bench for sp_exec_pipe. Directed scenarios are
//             followed by random traffic; expected writebacks are kept in
//             maps keyed by the cycle in which they must appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sp_exec_pipe;

    localparam int LANES     = 4;
    localparam int LAT_SHORT = 6;
    localparam int LAT_LONG  = 7;
    localparam int DW        = LANES * 32;

    localparam int K_IDLE = -1;
    localparam int K_AH   = 0;
    localparam int K_SFH  = 1;
    localparam int K_MPY  = 2;
    localparam int K_MPYU = 3;
    localparam int K_MPYH = 4;
    localparam int K_MPYA = 5;
    localparam int K_NOP  = 6;
    localparam int K_ILL  = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          issue_valid;
    logic [0:10]   op;
    logic [0:6]    rt_addr;
    logic [0:DW-1] ra;
    logic [0:DW-1] rb;
    logic [0:DW-1] rc;
    logic          reg_write;
    logic [0:DW-1] rt_wb;
    logic [0:6]    rt_addr_wb;
    logic          reg_write_wb;
    logic [0:DW-1] rt_int;
    logic [0:6]    rt_addr_int;
    logic          reg_write_int;
    logic          illegal_op;
    logic          busy;
`ifdef SP_EXEC_FWD_TAP_EN
    logic [0:LAT_LONG*(9+DW)-1] fwd_tap;
`endif

    sp_exec_pipe #(
        .LANES     (LANES),
        .LAT_SHORT (LAT_SHORT),
        .LAT_LONG  (LAT_LONG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .op            (op),
        .rt_addr       (rt_addr),
        .ra            (ra),
        .rb            (rb),
        .rc            (rc),
        .reg_write     (reg_write),
        .rt_wb         (rt_wb),
        .rt_addr_wb    (rt_addr_wb),
        .reg_write_wb  (reg_write_wb),
        .rt_int        (rt_int),
        .rt_addr_int   (rt_addr_int),
        .reg_write_int (reg_write_int),
        .illegal_op    (illegal_op),
`ifdef SP_EXEC_FWD_TAP_EN
        .fwd_tap       (fwd_tap),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int t0       = 0;

    // Expected writebacks, keyed by the cycle they are visible in.
    logic [0:DW-1] es_d  [int];
    logic [0:6]    es_a  [int];
    logic          es_rw [int];
    logic [0:DW-1] el_d  [int];
    logic [0:6]    el_a  [int];
    logic          el_rw [int];
    bit            ill_q [int];

    logic [0:10]   ill_ops [0:2];
    logic [0:DW-1] va;
    logic [0:DW-1] vb;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [0:DW-1] rand_vec();
        logic [0:DW-1] v;
        for (int l = 0; l < LANES; l++) v[l*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference: per-lane results from plain integer arithmetic.
    function automatic logic [0:DW-1] ref_result(input int kind, input logic [0:DW-1] a,
                                                 input logic [0:DW-1] b, input logic [0:DW-1] c);
        logic [0:DW-1] r;
        logic [31:0]   x, y, z;
        longint        xh, xl, yh, yl, p;
        shortint       sx, sy;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            x  = a[l*32 +: 32];
            y  = b[l*32 +: 32];
            z  = c[l*32 +: 32];
            xh = longint'(x / 65536);
            xl = longint'(x % 65536);
            yh = longint'(y / 65536);
            yl = longint'(y % 65536);
            sx = x[15:0];
            sy = y[15:0];
            case (kind)
                K_AH:   p = ((xh + yh) % 65536) * 65536 + (xl + yl) % 65536;
                K_SFH:  p = ((yh - xh + 65536) % 65536) * 65536 + (yl - xl + 65536) % 65536;
                K_MPY:  p = longint'(sx) * longint'(sy);
                K_MPYU: p = xl * yl;
                K_MPYH: p = xh * yl * 65536;
                K_MPYA: p = longint'(sx) * longint'(sy) + longint'(z);
                default: p = 0;
            endcase
            r[l*32 +: 32] = p[31:0];
        end
        return r;
    endfunction

    function automatic logic [0:10] opcode_for(input int kind);
        case (kind)
            K_AH:   return 11'b00011001000;
            K_SFH:  return 11'b00001001000;
            K_MPY:  return 11'b01111000100;
            K_MPYU: return 11'b01111001100;
            K_MPYH: return 11'b01111000101;
            K_MPYA: return {4'b1100, 7'($urandom())};
            K_NOP:  return {10'd0, 1'($urandom())};
            K_ILL:  return ill_ops[$urandom_range(0, 2)];
            default: return 11'($urandom());
        endcase
    endfunction

    // Apply one cycle of inputs and update the expectations accordingly.
    task automatic drive(input int kind, input logic [0:6] addr, input logic rw,
                         input logic fl, input logic rst_n,
                         input logic [0:DW-1] a, input logic [0:DW-1] b, input logic [0:DW-1] c);
        issue_valid = (kind != K_IDLE);
        op          = opcode_for(kind);
        rt_addr     = addr;
        reg_write   = rw;
        flush       = fl;
        reset       = rst_n;
        ra          = a;
        rb          = b;
        rc          = c;
        if (!rst_n || fl) begin
            es_d.delete(); es_a.delete(); es_rw.delete();
            el_d.delete(); el_a.delete(); el_rw.delete();
            ill_q.delete();
        end else if (kind == K_AH || kind == K_SFH) begin
            es_d[cyc+LAT_SHORT]  = ref_result(kind, a, b, c);
            es_a[cyc+LAT_SHORT]  = addr;
            es_rw[cyc+LAT_SHORT] = rw;
        end else if (kind >= K_MPY && kind <= K_MPYA) begin
            el_d[cyc+LAT_LONG]  = ref_result(kind, a, b, c);
            el_a[cyc+LAT_LONG]  = addr;
            el_rw[cyc+LAT_LONG] = rw;
        end else if (kind == K_ILL) begin
            ill_q[cyc+1] = 1'b1;
        end
    endtask

    task automatic drive_idle(input logic fl, input logic rst_n);
        drive(K_IDLE, 7'($urandom()), 1'($urandom()), fl, rst_n, rand_vec(), rand_vec(), rand_vec());
    endtask

    task automatic check_outputs();
        logic [0:DW-1] ed;
        logic [0:6]    ea;
        logic          erw;
        logic          eb;
        eb = (es_d.num() > 0) || (el_d.num() > 0);
        if (es_d.exists(cyc)) begin
            ed = es_d[cyc]; ea = es_a[cyc]; erw = es_rw[cyc];
        end else begin
            ed = '0; ea = '0; erw = 1'b0;
        end
        chk("wb_data", rt_wb, ed);
        chk("wb_addr", rt_addr_wb, ea);
        chk("wb_regw", reg_write_wb, erw);
        if (el_d.exists(cyc)) begin
            ed = el_d[cyc]; ea = el_a[cyc]; erw = el_rw[cyc];
        end else begin
            ed = '0; ea = '0; erw = 1'b0;
        end
        chk("int_data", rt_int, ed);
        chk("int_addr", rt_addr_int, ea);
        chk("int_regw", reg_write_int, erw);
        chk("illegal_op", illegal_op, ill_q.exists(cyc));
        chk("busy", busy, eb);
        es_d.delete(cyc); es_a.delete(cyc); es_rw.delete(cyc);
        el_d.delete(cyc); el_a.delete(cyc); el_rw.delete(cyc);
        ill_q.delete(cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive_idle(1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        int kind;
        logic fl;
        logic rs;

        ill_ops[0] = 11'b11111111111;
        ill_ops[1] = 11'b00000000010;
        ill_ops[2] = 11'b01111000110;

        reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; op = '0;
        rt_addr = '0; reg_write = 1'b0; ra = '0; rb = '0; rc = '0;

        // Reset state
        tick();
        drive_idle(1'b0, 1'b0);
        tick();
        idle(2);

        // MPY of -1 * 2 on lane 0
        va = '0; vb = '0;
        va[0:31] = 32'h0000FFFF;
        vb[0:31] = 32'h00000002;
        drive(K_MPY, 7'd5, 1'b1, 1'b0, 1'b1, va, vb, rand_vec());
        t0 = cyc;
        tick();
        idle(6);
        chk("mpy_lat_data", rt_int[0:31], 32'hFFFFFFFE);
        chk("mpy_lat_addr", rt_addr_int, 7'd5);
        chk("mpy_wb_zero", rt_wb, '0);
        idle(2);

        // AH halfword carry isolation
        va = rand_vec(); vb = rand_vec();
        va[0:31] = 32'h7FFF0001;
        vb[0:31] = 32'h00010001;
        drive(K_AH, 7'd9, 1'b1, 1'b0, 1'b1, va, vb, rand_vec());
        tick();
        idle(5);
        chk("ah_lat_data", rt_wb[0:31], 32'h80000002);
        idle(2);

        // Long at t, short at t+1: both complete at t+7
        drive(K_MPY, 7'd3, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec());
        tick();
        drive(K_AH, 7'd12, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec());
        tick();
        idle(5);
        chk("both_int_addr", rt_addr_int, 7'd3);
        chk("both_wb_addr", rt_addr_wb, 7'd12);
        idle(2);

        // MPYA flushed three cycles after issue
        drive(K_MPYA, 7'd20, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec());
        tick();
        idle(2);
        drive_idle(1'b1, 1'b1);
        tick();
        chk("flush_busy", busy, 1'b0);
        idle(8);

        // Illegal opcode
        va = rand_vec();
        drive(K_ILL, 7'd1, 1'b1, 1'b0, 1'b1, va, rand_vec(), rand_vec());
        op = 11'b11111111111;
        tick();
        chk("illegal_pulse", illegal_op, 1'b1);
        idle(8);

        // Reset with four entries in flight
        drive(K_MPY,  7'd10, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec()); tick();
        drive(K_AH,   7'd11, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec()); tick();
        drive(K_MPYA, 7'd12, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec()); tick();
        drive(K_SFH,  7'd13, 1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), rand_vec()); tick();
        drive_idle(1'b0, 1'b0);
        tick();
        chk("reset_busy", busy, 1'b0);
        idle(10);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 15) kind = K_IDLE;
            else kind = $urandom_range(0, 7);
            fl = ($urandom_range(0, 99) < 3) && (kind != K_ILL);
            rs = ($urandom_range(0, 199) != 0);
            drive(kind, 7'($urandom()), 1'($urandom()), fl, rs, rand_vec(), rand_vec(), rand_vec());
            tick();
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
